// File: rtl/control_unit.sv
// rtl/control_unit.sv - MIPS-subset instruction decoder with sticky illegal-instruction flag
module control_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    output logic        reg_write,
    output logic [1:0]  alu_src,
    output logic [2:0]  alu_op,
    output logic [4:0]  addr_a,
    output logic [4:0]  addr_b,
    output logic [4:0]  addr_in,
    output logic [4:0]  shamt,
    output logic [15:0] imm16,
    output logic [25:0] addr26,
    output logic        is_jump,
    output logic        is_branch,
    output logic        mem_read,
    output logic        mem_write,
    output logic        illegal,
    output logic        illegal_seen
);

    localparam logic [1:0] SRC_REG_B   = 2'd0;
    localparam logic [1:0] SRC_SEXT_16 = 2'd1;
    localparam logic [1:0] SRC_ZEXT_16 = 2'd2;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_NOR = 3'd4;
    localparam logic [2:0] ALU_SLT = 3'd5;
    localparam logic [2:0] ALU_SLL = 3'd6;
    localparam logic [2:0] ALU_SRL = 3'd7;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] sh;
    logic [5:0] funct;

    assign op     = instruction[31:26];
    assign rs     = instruction[25:21];
    assign rt     = instruction[20:16];
    assign rd     = instruction[15:11];
    assign sh     = instruction[10:6];
    assign funct  = instruction[5:0];
    assign imm16  = instruction[15:0];
    assign addr26 = instruction[25:0];
    assign addr_b = rt;

    always_comb begin
        reg_write = 1'b0;
        alu_src   = SRC_REG_B;
        alu_op    = ALU_ADD;
        addr_a    = rs;
        addr_in   = rd;
        shamt     = 5'd0;
        is_jump   = 1'b0;
        is_branch = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        illegal   = 1'b0;

        case (op)
            OP_RTYPE: begin
                reg_write = 1'b1;
                case (funct)
                    FN_ADD: alu_op = ALU_ADD;
                    FN_SUB: alu_op = ALU_SUB;
                    FN_AND: alu_op = ALU_AND;
                    FN_OR:  alu_op = ALU_OR;
                    FN_NOR: alu_op = ALU_NOR;
                    FN_SLT: alu_op = ALU_SLT;
                    // Shifts operate on rt, so it is routed to port A with the shift amount.
                    FN_SLL: begin
                        alu_op = ALU_SLL;
                        addr_a = rt;
                        shamt  = sh;
                    end
                    FN_SRL: begin
                        alu_op = ALU_SRL;
                        addr_a = rt;
                        shamt  = sh;
                    end
                    FN_JR: begin
                        reg_write = 1'b0;
                        is_jump   = 1'b1;
                    end
                    default: begin
                        reg_write = 1'b0;
                        illegal   = 1'b1;
                    end
                endcase
            end
            OP_ADDI: begin
                alu_src   = SRC_SEXT_16;
                addr_in   = rt;
                reg_write = 1'b1;
            end
            OP_ANDI: begin
                alu_op    = ALU_AND;
                alu_src   = SRC_ZEXT_16;
                addr_in   = rt;
                reg_write = 1'b1;
            end
            OP_ORI: begin
                alu_op    = ALU_OR;
                alu_src   = SRC_ZEXT_16;
                addr_in   = rt;
                reg_write = 1'b1;
            end
            OP_LW: begin
                alu_src   = SRC_SEXT_16;
                addr_in   = rt;
                reg_write = 1'b1;
                mem_read  = 1'b1;
            end
            OP_SW: begin
                alu_src   = SRC_SEXT_16;
                mem_write = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                alu_op    = ALU_SUB;
                is_branch = 1'b1;
            end
            OP_J: is_jump = 1'b1;
            OP_JAL: begin
                is_jump   = 1'b1;
                reg_write = 1'b1;
                addr_in   = 5'd31;
            end
            default: illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_seen <= 1'b0;
        end else if (illegal) begin
            illegal_seen <= 1'b1;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - table-driven decode checks plus sticky illegal flag sequences
module tb_control_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic        reg_write;
    logic [1:0]  alu_src;
    logic [2:0]  alu_op;
    logic [4:0]  addr_a;
    logic [4:0]  addr_b;
    logic [4:0]  addr_in;
    logic [4:0]  shamt;
    logic [15:0] imm16;
    logic [25:0] addr26;
    logic        is_jump;
    logic        is_branch;
    logic        mem_read;
    logic        mem_write;
    logic        illegal;
    logic        illegal_seen;

    int errors = 0;
    int checks = 0;

    control_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instruction  (instruction),
        .reg_write    (reg_write),
        .alu_src      (alu_src),
        .alu_op       (alu_op),
        .addr_a       (addr_a),
        .addr_b       (addr_b),
        .addr_in      (addr_in),
        .shamt        (shamt),
        .imm16        (imm16),
        .addr26       (addr26),
        .is_jump      (is_jump),
        .is_branch    (is_branch),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .illegal      (illegal),
        .illegal_seen (illegal_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        rw;
        logic [1:0]  src;
        logic [2:0]  op;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [4:0]  win;
        logic [4:0]  sh;
        logic        jmp;
        logic        br;
        logic        mr;
        logic        mw;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic [31:0] instr, logic rw, logic [1:0] src,
                                logic [2:0] op, logic [4:0] a, logic [4:0] b, logic [4:0] win,
                                logic [4:0] sh, logic jmp, logic br, logic mr, logic mw, logic ill);
        vec_t v;
        v.name = name; v.instr = instr; v.rw = rw; v.src = src; v.op = op;
        v.a = a; v.b = b; v.win = win; v.sh = sh; v.jmp = jmp; v.br = br;
        v.mr = mr; v.mw = mw; v.ill = ill;
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        //            name          instr         rw src op  a   b   in  sh j br mr mw ill
        vecs.push_back(mk("addi",   32'h2010FEFE, 1, 1, 0,  0, 16, 16,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("sll",    32'h00108400, 1, 0, 6, 16, 16, 16, 16, 0, 0, 0, 0, 0));
        vecs.push_back(mk("srl",    32'h00104042, 1, 0, 7, 16, 16,  8,  1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("sll31",  32'h000A07C0, 1, 0, 6, 10, 10,  0, 31, 0, 0, 0, 0, 0));
        vecs.push_back(mk("sub",    32'h02114022, 1, 0, 1, 16, 17,  8,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("slt",    32'h0111482A, 1, 0, 5,  8, 17,  9,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("and",    32'h02114024, 1, 0, 2, 16, 17,  8,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("or",     32'h02114025, 1, 0, 3, 16, 17,  8,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("nor",    32'h02114027, 1, 0, 4, 16, 17,  8,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("add",    32'h01095020, 1, 0, 0,  8,  9, 10,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("andi",   32'h320900CF, 1, 2, 2, 16,  9,  9,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("ori",    32'h360900C0, 1, 2, 3, 16,  9,  9,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("lw",     32'h8E090004, 1, 1, 0, 16,  9,  9,  0, 0, 0, 1, 0, 0));
        vecs.push_back(mk("sw",     32'hAE090004, 0, 1, 0, 16,  9,  0,  0, 0, 0, 0, 1, 0));
        vecs.push_back(mk("beq",    32'h11090003, 0, 0, 1,  8,  9,  0,  0, 0, 1, 0, 0, 0));
        vecs.push_back(mk("bne",    32'h1520FFFD, 0, 0, 1,  9,  0, 31,  0, 0, 1, 0, 0, 0));
        vecs.push_back(mk("j",      32'h08000040, 0, 0, 0,  0,  0,  0,  0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("jal",    32'h0C000010, 1, 0, 0,  0,  0, 31,  0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("jr",     32'h03E00008, 0, 0, 0, 31,  0,  0,  0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("ill_op", 32'hFC000000, 0, 0, 0,  0,  0,  0,  0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("ill_op2",32'hFE1F07C0, 0, 0, 0, 16, 31,  0,  0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("ill_fn", 32'h0000003F, 0, 0, 0,  0,  0,  0,  0, 0, 0, 0, 0, 1));

        rst_n = 1'b0;
        instruction = 32'h0;
        @(posedge clk); #1;
        check("reset_illegal_seen", 64'(illegal_seen), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            logic [30:0] act_pack;
            logic [30:0] exp_pack;
            instruction = vecs[i].instr;
            #1;
            act_pack = {reg_write, alu_src, alu_op, addr_a, addr_b, addr_in, shamt,
                        is_jump, is_branch, mem_read, mem_write, illegal};
            exp_pack = {vecs[i].rw, vecs[i].src, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].win,
                        vecs[i].sh, vecs[i].jmp, vecs[i].br, vecs[i].mr, vecs[i].mw, vecs[i].ill};
            check({vecs[i].name, "_ctrl"}, 64'(act_pack), 64'(exp_pack));
            check({vecs[i].name, "_fields"}, {22'd0, imm16, addr26},
                  {22'd0, vecs[i].instr[15:0], vecs[i].instr[25:0]});
        end

        // Sticky flag: illegal vectors above already set it; clear and redo deliberately.
        #2 rst_n = 1'b0;
        #1 check("async_clear_1", 64'(illegal_seen), 64'd0);
        rst_n = 1'b1;
        instruction = 32'h01095020;
        @(posedge clk); #1;
        check("legal_no_set", 64'(illegal_seen), 64'd0);

        instruction = 32'hFC000000;
        #1;
        check("ill_comb_now", 64'({illegal, reg_write}), 64'b10);
        check("seen_before_edge", 64'(illegal_seen), 64'd0);
        @(posedge clk); #1;
        check("seen_after_edge", 64'(illegal_seen), 64'd1);

        instruction = 32'h2010FEFE;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("seen_sticky", 64'(illegal_seen), 64'd1);

        #3 rst_n = 1'b0;
        #1 check("async_clear_mid", 64'(illegal_seen), 64'd0);

        // Combinational decode unaffected by reset; flag stays clear while held.
        instruction = 32'hFC000000;
        #1 check("reset_comb_ill", 64'(illegal), 64'd1);
        instruction = 32'h0C000010;
        #1 check("reset_comb_jal", 64'({is_jump, reg_write, addr_in}), {57'd0, 2'b11, 5'd31});
        instruction = 32'hFC000000;
        @(posedge clk); #1;
        check("reset_holds_clear", 64'(illegal_seen), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("set_after_release", 64'(illegal_seen), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have no parameters; all encodings are fixed by this document.
REQ-002 clk  input  1  single clock; used only by the sticky illegal-instruction register.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 instruction  input  32  current MIPS instruction word.
REQ-005 reg_write  output  1  register-file write enable.
REQ-006 alu_src  output  2  ALU B-operand select: 0 REG_B, 1 SEXT_IMM16, 2 ZEXT_IMM16.
REQ-007 alu_op  output  3  ALU operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 SLT, 6 SLL, 7 SRL.
REQ-008 addr_a, addr_b, addr_in  output  5 each  register read port A, read port B, write port.
REQ-009 shamt  output  5  shift amount.
REQ-010 imm16  output  16  immediate field.
REQ-011 addr26  output  26  jump target field.
REQ-012 is_jump, is_branch  output  1 each  unconditional jump / conditional branch.
REQ-013 mem_read, mem_write  output  1 each  data-memory load / store enable.
REQ-014 illegal  output  1  current instruction is not supported (combinational).
REQ-015 illegal_seen  output  1  sticky registered flag; set once any illegal instruction is sampled.

Function
REQ-016 All outputs except illegal_seen SHALL be purely combinational in instruction, with zero-cycle latency.
REQ-017 Fields: op = [31:26], rs = [25:21], rt = [20:16], rd = [15:11], sh = [10:6], funct = [5:0].
REQ-018 imm16 SHALL always equal [15:0], and addr26 SHALL always equal [25:0].
REQ-019 addr_b SHALL equal rt for every instruction.
REQ-020 addr_a SHALL equal rs, except for sll/srl, where addr_a SHALL equal rt.
REQ-021 shamt SHALL equal sh for sll/srl and 0 for all other instructions.
REQ-022 R-type (op 0x00) SHALL decode as: funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt, 0x00 sll, 0x02 srl, each with reg_write = 1, addr_in = rd, alu_src = REG_B.
REQ-023 R-type funct 0x08 (jr) SHALL give is_jump = 1 and reg_write = 0.
REQ-024 I-type addi (0x08) SHALL give alu_op ADD, alu_src SEXT_IMM16, addr_in = rt, reg_write = 1.
REQ-025 I-type andi (0x0C) and ori (0x0D) SHALL give alu_op AND and OR respectively, alu_src ZEXT_IMM16, addr_in = rt, reg_write = 1.
REQ-026 lw (0x23) SHALL give ADD, SEXT_IMM16, addr_in = rt, reg_write = 1, mem_read = 1.
REQ-027 sw (0x2B) SHALL give ADD, SEXT_IMM16, mem_write = 1, reg_write = 0.
REQ-028 beq (0x04) and bne (0x05) SHALL give is_branch = 1, alu_op SUB, alu_src REG_B, reg_write = 0.
REQ-029 j (0x02) SHALL give is_jump = 1 and reg_write = 0.
REQ-030 jal (0x03) SHALL give is_jump = 1, reg_write = 1, addr_in = 31.
REQ-031 Defaults for any output not named above: reg_write, mem_read, mem_write, is_jump, is_branch = 0; alu_op ADD; alu_src REG_B; addr_in = rd.
REQ-032 Any other op or funct SHALL assert illegal = 1 with all defaults, so no write, no memory access and no control transfer occur.
REQ-033 No X or latch SHALL appear on any output for any 32-bit input.

Reset
REQ-034 rst_n low SHALL clear illegal_seen to 0 immediately, independent of clk.
REQ-035 With rst_n high, illegal_seen SHALL set on a rising clk edge when illegal = 1 and SHALL hold until reset.
REQ-036 Reset SHALL NOT affect the combinational outputs.

Verification
REQ-037 instruction 0x2010FEFE (addi) -> addr_a 0, addr_in 16, imm16 0xFEFE, alu_op ADD, alu_src SEXT_IMM16, shamt 0, is_jump 0, is_branch 0, reg_write 1.
REQ-038 instruction 0x00108400 (sll) -> addr_a 16, addr_in 16, shamt 16, alu_op SLL; instruction 0x00104042 (srl) -> addr_a 16, addr_in 8, shamt 1, alu_op SRL.
REQ-039 instructions 0x02114022 / 0x0111482A / 0x02114024 / 0x02114025 / 0x02114027 -> alu_op SUB / SLT / AND / OR / NOR, each with addr_a and addr_b taken from rs and rt, addr_in from rd, shamt 0.
REQ-040 instruction 0x320900CF (andi) -> addr_a 16, addr_in 9, imm16 0x00CF, alu_op AND, alu_src ZEXT; instruction 0x360900C0 (ori) -> alu_op OR.
REQ-041 instruction 0x1520FFFD (bne) -> is_branch 1, addr_a 9, addr_b 0, imm16 0xFFFD, reg_write 0; instruction 0x0C000010 (jal) -> is_jump 1, addr_in 31, reg_write 1.
REQ-042 Apply op 0x3F -> illegal 1 and reg_write 0, and illegal_seen rises at the next clk edge; assert rst_n low mid-cycle -> illegal_seen 0 at once.
